lm32_dtlb_refill: RTL
=====================

Name: lm32_dtlb_refill

Overview:
- Hardware page-table walker that fills the data TLB on a miss, replacing the software-managed CSR refill.
- Accepts a miss request (virtual address), performs a two-level walk in memory over a dedicated read-only Wishbone master port, then emits a TLB update (vaddr, paddr pair) or a fault.
- Sits beside the DTLB in the LM32 core; its update outputs drive the same write port the TLB-update CSRs drive.

Parameters:
- page_size, 4096, system page size in bytes (power of two, >= 1024); P = CLOG2(page_size) offset bits.
- pt_index_width, CLOG2(page_size)-2, second-level index bits (page_size/4 entries per table page).
- pd_index_width, 32-P-pt_index_width, directory index bits (10/10 for 4 KB pages).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- enable  in  1  walker enable; when low, requests are ignored.
- refill_req  in  1  miss request, level, sampled only in IDLE.
- refill_address  in  32  faulting virtual address.
- csr  in  LM32_CSR_RNG  CSR index.
- csr_write_data  in  32  CSR write data.
- csr_write_enable  in  1  CSR write strobe.
- csr_read_data  out  32  PTBR value.
- refill_busy  out  1  walk in progress (any state except IDLE).
- refill_done  out  1  one-cycle pulse; TLB updated.
- refill_fault  out  1  one-cycle pulse; walk failed.
- fault_cause  out  2  01 PDE invalid, 10 PTE invalid, 11 bus error; held until the next walk starts.
- tlb_update  out  1  one-cycle TLB write strobe (coincident with refill_done).
- tlb_vaddr  out  32  {va[31:P], P'b0}.
- tlb_paddr  out  32  {pte[31:P], P'b0}.
- pw_cyc_o, pw_stb_o  out  1  Wishbone cycle/strobe.
- pw_adr_o  out  32  Wishbone address.
- pw_dat_i  in  32  Wishbone read data.
- pw_ack_i, pw_err_i  in  1  Wishbone acknowledge/error.
- pw_we_o is tied 0; pw_sel_o is tied 4'hF.

Interface decision: one clock (clk_i); reset rst_i is synchronous, active-high.

Behaviour:
- Reset values: state IDLE, PTBR 0, all outputs 0, fault_cause 00.
- PTBR CSR (LM32_CSR_PTBR) stores bits [31:P]; the low bits always read 0. Writes are accepted in any state but take effect only at the next walk, because the PDE address is latched at accept.
- States: IDLE, PDE_REQ, PDE_CHECK, PTE_REQ, FINISH.
- IDLE: when enable && refill_req:
  - latch va = refill_address;
  - compute pde_addr = {ptbr[31:P], va[31:32-pd_index_width], 2'b00};
  - clear fault_cause;
  - go to PDE_REQ.
- PDE_REQ: pw_cyc_o = pw_stb_o = 1, pw_adr_o = pde_addr.
  - On pw_ack_i: latch pw_dat_i as pde and go to PDE_CHECK.
  - On pw_err_i: fault_cause = 11 and go to FINISH. err takes priority if ack and err are both high.
- PDE_CHECK: cyc/stb are low for exactly one cycle.
  - If pde[0] = 0: fault_cause = 01, go to FINISH.
  - Else: pte_addr = {pde[31:P], va[P+pt_index_width-1:P], 2'b00}, go to PTE_REQ.
- PTE_REQ: same bus rules as PDE_REQ. On ack, latch pte and go to FINISH, with fault_cause = 10 if pte[0] = 0.
- FINISH: one cycle, then IDLE.
  - fault_cause == 00: tlb_update = refill_done = 1.
  - Otherwise: refill_fault = 1.
- Minimum latency with zero-wait acks: request sampled at cycle 0 → PDE bus cycle at 1 → check at 2 → PTE bus cycle at 3 → done pulse at 4 → IDLE at 5.
- Outputs are registered. pw_cyc_o and pw_stb_o drop in the cycle after ack/err.
- refill_req is ignored while busy. A request held high after done starts a new walk from IDLE; the requester must drop it once it sees done or fault.
- enable deasserted mid-walk: the walk completes normally (a bus cycle is never abandoned).
- Reset mid-walk: cyc/stb drop on the next edge with no update pulse.
- tlb_vaddr and tlb_paddr are stable from FINISH until the next accept.

Decomposition:
- Shared include (lm32_include.v):
  - LM32_CSR_PTBR index;
  - fault-cause codes LM32_PTW_FAULT_{NONE,PDE,PTE,BUS};
  - state encodings LM32_PTW_STATE_*.
- Single module; address generation is two concatenations, so no sub-module is warranted.

Test Plan:
- Valid walk, page_size 4096: PTBR = 0x0010_0000, va = 0x4030_2ABC. Expect a PDE read at 0x0010_0400. With PDE = 0x0020_0001, expect a PTE read at 0x0020_0C08. With PTE = 0x0801_3001, expect tlb_vaddr = 0x4030_2000, tlb_paddr = 0x0801_3000, done at cycle 4.
- PDE invalid: PDE = 0x0020_0000. Expect only one bus cycle, refill_fault, fault_cause = 01, no tlb_update.
- PTE invalid: PTE bit0 = 0. Expect fault_cause = 10 after two bus cycles, no update.
- Bus error on the PTE access: pw_err_i = 1 (with ack also high). Expect fault_cause = 11, cyc low the next cycle.
- Three wait states per ack, and a PTBR write to 0x0030_0000 mid-walk. Expect the walk to use the old PTBR; the next walk reads at 0x0030_0xxx. Expect refill_req to be ignored while busy.
- Reset asserted during PTE_REQ. Expect cyc/stb = 0 and all pulses 0 the next cycle, PTBR = 0, and a fresh walk to work afterwards.

Source files
------------

// File: rtl/lm32_dtlb_refill_pkg.sv
// Shared definitions for the LM32 data-TLB hardware page-table walker:
// CSR index, fault-cause codes and walker state encodings.
package lm32_dtlb_refill_pkg;

    localparam int LM32_CSR_WIDTH = 5;
    localparam logic [LM32_CSR_WIDTH-1:0] LM32_CSR_PTBR = 5'h1C;

    typedef logic [1:0] lm32_ptw_fault_t;

    localparam lm32_ptw_fault_t LM32_PTW_FAULT_NONE = 2'b00;
    localparam lm32_ptw_fault_t LM32_PTW_FAULT_PDE  = 2'b01;
    localparam lm32_ptw_fault_t LM32_PTW_FAULT_PTE  = 2'b10;
    localparam lm32_ptw_fault_t LM32_PTW_FAULT_BUS  = 2'b11;

    typedef enum logic [2:0] {
        LM32_PTW_STATE_IDLE      = 3'd0,
        LM32_PTW_STATE_PDE_REQ   = 3'd1,
        LM32_PTW_STATE_PDE_CHECK = 3'd2,
        LM32_PTW_STATE_PTE_REQ   = 3'd3,
        LM32_PTW_STATE_FINISH    = 3'd4
    } lm32_ptw_state_t;

endpackage

// File: rtl/lm32_dtlb_refill.sv
// Two-level hardware page-table walker that refills the LM32 data TLB over a
// dedicated read-only Wishbone master port.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for an enabled miss request
// PDE_REQ   | Wishbone read of the page-directory entry
// PDE_CHECK | one bus-idle cycle: test PDE valid bit, form PTE address
// PTE_REQ   | Wishbone read of the page-table entry
// FINISH    | one cycle: TLB update strobe or fault pulse
module lm32_dtlb_refill
    import lm32_dtlb_refill_pkg::*;
#(
    parameter int page_size = 4096
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable,
    input  logic                      refill_req,
    input  logic [31:0]               refill_address,
    input  logic [LM32_CSR_WIDTH-1:0] csr,
    input  logic [31:0]               csr_write_data,
    input  logic                      csr_write_enable,
    output logic [31:0]               csr_read_data,
    output logic                      refill_busy,
    output logic                      refill_done,
    output logic                      refill_fault,
    output logic [1:0]                fault_cause,
    output logic                      tlb_update,
    output logic [31:0]               tlb_vaddr,
    output logic [31:0]               tlb_paddr,
    output logic                      pw_cyc_o,
    output logic                      pw_stb_o,
    output logic [31:0]               pw_adr_o,
    input  logic [31:0]               pw_dat_i,
    input  logic                      pw_ack_i,
    input  logic                      pw_err_i,
    output logic                      pw_we_o,
    output logic [3:0]                pw_sel_o
);

    localparam int P   = $clog2(page_size);
    localparam int PTW = P - 2;
    localparam int PDW = 32 - P - PTW;

    lm32_ptw_state_t state_q, state_d;

    logic [31:P]     ptbr_q;
    logic [31:P]     va_q;
    logic [31:P]     pde_base_q;
    logic            pde_valid_q;
    logic [31:P]     pte_base_q;
    logic [31:0]     adr_q;
    lm32_ptw_fault_t fault_q;

    logic            accept;
    logic [PDW-1:0]  dir_idx;
    logic [31:0]     pde_addr;
    logic [31:0]     pte_addr;
    logic            unused_bits;

    assign accept   = (state_q == LM32_PTW_STATE_IDLE) && enable && refill_req;
    assign dir_idx  = refill_address[31:32-PDW];
    // OR rather than concatenate so the directory may span several pages for small page sizes.
    assign pde_addr = {ptbr_q, {P{1'b0}}} | 32'({dir_idx, 2'b00});
    assign pte_addr = {pde_base_q, va_q[P+PTW-1:P], 2'b00};

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= LM32_PTW_STATE_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LM32_PTW_STATE_IDLE:
                if (accept) state_d = LM32_PTW_STATE_PDE_REQ;
            LM32_PTW_STATE_PDE_REQ:
                if (pw_err_i)      state_d = LM32_PTW_STATE_FINISH;
                else if (pw_ack_i) state_d = LM32_PTW_STATE_PDE_CHECK;
            LM32_PTW_STATE_PDE_CHECK:
                state_d = pde_valid_q ? LM32_PTW_STATE_PTE_REQ : LM32_PTW_STATE_FINISH;
            LM32_PTW_STATE_PTE_REQ:
                if (pw_err_i || pw_ack_i) state_d = LM32_PTW_STATE_FINISH;
            LM32_PTW_STATE_FINISH:
                state_d = LM32_PTW_STATE_IDLE;
            default:
                state_d = LM32_PTW_STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptbr_q      <= '0;
            va_q        <= '0;
            pde_base_q  <= '0;
            pde_valid_q <= 1'b0;
            pte_base_q  <= '0;
            adr_q       <= '0;
            fault_q     <= LM32_PTW_FAULT_NONE;
        end else begin
            if (csr_write_enable && (csr == LM32_CSR_PTBR))
                ptbr_q <= csr_write_data[31:P];
            case (state_q)
                LM32_PTW_STATE_IDLE:
                    if (accept) begin
                        va_q    <= refill_address[31:P];
                        adr_q   <= pde_addr;
                        fault_q <= LM32_PTW_FAULT_NONE;
                    end
                LM32_PTW_STATE_PDE_REQ:
                    if (pw_err_i) begin
                        fault_q <= LM32_PTW_FAULT_BUS;
                    end else if (pw_ack_i) begin
                        pde_base_q  <= pw_dat_i[31:P];
                        pde_valid_q <= pw_dat_i[0];
                    end
                LM32_PTW_STATE_PDE_CHECK:
                    if (!pde_valid_q)
                        fault_q <= LM32_PTW_FAULT_PDE;
                    else
                        adr_q <= pte_addr;
                LM32_PTW_STATE_PTE_REQ:
                    if (pw_err_i) begin
                        fault_q <= LM32_PTW_FAULT_BUS;
                    end else if (pw_ack_i) begin
                        pte_base_q <= pw_dat_i[31:P];
                        if (!pw_dat_i[0])
                            fault_q <= LM32_PTW_FAULT_PTE;
                    end
                default: ;
            endcase
        end
    end

    assign refill_busy   = (state_q != LM32_PTW_STATE_IDLE);
    assign pw_cyc_o      = (state_q == LM32_PTW_STATE_PDE_REQ) || (state_q == LM32_PTW_STATE_PTE_REQ);
    assign pw_stb_o      = pw_cyc_o;
    assign pw_adr_o      = adr_q;
    assign pw_we_o       = 1'b0;
    assign pw_sel_o      = 4'hF;
    assign tlb_update    = (state_q == LM32_PTW_STATE_FINISH) && (fault_q == LM32_PTW_FAULT_NONE);
    assign refill_done   = tlb_update;
    assign refill_fault  = (state_q == LM32_PTW_STATE_FINISH) && (fault_q != LM32_PTW_FAULT_NONE);
    assign fault_cause   = fault_q;
    assign tlb_vaddr     = {va_q, {P{1'b0}}};
    assign tlb_paddr     = {pte_base_q, {P{1'b0}}};
    assign csr_read_data = (csr == LM32_CSR_PTBR) ? {ptbr_q, {P{1'b0}}} : 32'h0;

    assign unused_bits = ^{refill_address[P-1:0], csr_write_data[P-1:0], pw_dat_i[P-1:1]};

endmodule
